// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcode/funct
// values, ALU control codes and datapath mux encodings.
package cu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_MEM = 4'd8,
        S_WB_ALU = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic funct_known(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    // Unknown funct falls back to ADD; the instruction is dropped anyway.
    function automatic logic [3:0] funct_to_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory access is left waiting and flags the
// cycle in which one more wait would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Any cycle outside a waiting memory state clears the count, so each
    // memory state starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (active && !mem_ready) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

    // A ready arriving on the final edge wins over the timeout.
    assign expired = active && !mem_ready && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/
// writeback and drives the shared-datapath selects and enables.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUCTL_W = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [5:0]          funct,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                bus_error,
    output logic [3:0]          state
);

    state_t     state_q;
    logic       mem_active;
    logic       expired;
    logic [5:0] op;
    logic       op_known;
    logic [3:0] alu_ctl;

    assign op         = 6'(opcode);
    assign op_known   = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                        (op == OP_ADDI)  || (op == OP_BEQ) || (op == OP_J);
    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (mem_active),
        .mem_ready (mem_ready),
        .expired   (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bus_error <= 1'b0;
        end else if (expired) begin
            state_q   <= S_HALT;
            bus_error <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE:   if (run) state_q <= S_FETCH;
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    if (op == OP_RTYPE)                     state_q <= S_EXEC_R;
                    else if ((op == OP_LW) || (op == OP_SW)) state_q <= S_ADDR;
                    else if (op == OP_ADDI)                 state_q <= S_EXEC_I;
                    else if (op == OP_BEQ)                  state_q <= S_BRANCH;
                    else if (op == OP_J)                    state_q <= S_JUMP;
                    else                                    state_q <= S_FETCH;
                end
                S_EXEC_R: state_q <= funct_known(funct) ? S_WB_ALU : S_FETCH;
                S_EXEC_I: state_q <= S_WB_ALU;
                S_ADDR:   state_q <= (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (mem_ready) state_q <= S_WB_MEM;
                S_MEM_WR: if (mem_ready) state_q <= S_FETCH;
                S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: state_q <= S_FETCH;
                S_HALT:   state_q <= S_HALT;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the registered state; only the FETCH strobes look at mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_ctl       = ALU_AND;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = SRCB_FOUR;
                alu_ctl   = ALU_ADD;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                alu_ctl    = ALU_ADD;
                illegal_op = !op_known;
            end
            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_ctl    = funct_to_alu(funct);
                illegal_op = !funct_known(funct);
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctl   = ALU_ADD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (op == OP_RTYPE);
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctl       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign alu_control = ALUCTL_W'(alu_ctl);
    assign state       = state_q;

endmodule
